sigmoid_alu_mult_pipe: RTL and testbench

//   Pipelined, parametrised signed x unsigned fixed-point multiplier for the sigmoid ALU datapath.

---
 rtl/sigmoid_alu_mult_pipe.sv | 145 ++++++++++++++
 tb/tb_sigmoid_alu_mult_pipe.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sigmoid_alu_mult_pipe.sv
// rtl/sigmoid_alu_mult_pipe.sv - pipelined signed x unsigned fixed-point multiplier with rescale and saturation
//
// Two-stage elastic pipeline:
//   S1 registers the full-precision product.
//   S2 rescales it to OFRAC fraction bits, saturates it to OW bits and holds the result
//   until downstream takes it.
//
// Ports:
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   clear                 synchronous flush of in-flight data and sat_count
//   in_valid / in_ready   operand handshake
//   signval, unsignval    signed (SW bits) and unsigned (UW bits) operands
//   out_valid / out_ready result handshake
//   out, out_sat          saturated signed result, clip flag
//   sat_count             clipped results delivered (sticky at all-ones)
module sigmoid_alu_mult_pipe #(
    parameter int SW    = 4,
    parameter int SFRAC = 0,
    parameter int UW    = 4,
    parameter int UFRAC = 3,
    parameter int OW    = 8,
    parameter int OFRAC = 3,
    parameter int ROUND = 0,
    parameter int CW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [SW-1:0] signval,
    input  logic [UW-1:0] unsignval,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [OW-1:0] out,
    output logic          out_sat,
    output logic [CW-1:0] sat_count
);

    localparam int SH = SFRAC + UFRAC - OFRAC;
    localparam int PW = SW + UW + 1;
    // One guard bit so the rounding add cannot wrap.
    localparam int RW = PW + 1;
    // Comparison width wide enough for both the rescaled value and the output limits.
    localparam int XW = ((RW > OW) ? RW : OW) + 1;

    localparam logic signed [XW-1:0] MAXV = {{(XW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [XW-1:0] MINV = {{(XW-OW+1){1'b1}}, {(OW-1){1'b0}}};

    generate
        if (SH < 0) begin : g_bad_shift
            $error("sigmoid_alu_mult_pipe: SFRAC+UFRAC-OFRAC must be >= 0");
        end
    endgenerate

    logic                 s1_valid;
    logic signed [PW-1:0] s1_p;

    logic signed [PW-1:0] s_ext;
    logic signed [PW-1:0] u_ext;
    logic signed [PW-1:0] prod;
    logic signed [RW-1:0] p_wide;
    logic signed [RW-1:0] r;
    logic signed [XW-1:0] rx;
    logic [OW-1:0]        sat_val;
    logic                 sat_flag;

    logic s2_adv;
    logic accept;
    logic consume;

    // The unsigned operand gets a zero sign bit so a signed multiply gives the true product.
    assign s_ext  = {{(UW+1){signval[SW-1]}}, signval};
    assign u_ext  = {{(SW+1){1'b0}}, unsignval};
    assign prod   = s_ext * u_ext;

    assign p_wide = {s1_p[PW-1], s1_p};

    generate
        if (SH <= 0) begin : g_noshift
            assign r = p_wide;
        end else if (ROUND != 0) begin : g_round
            localparam logic signed [RW-1:0] HALF = RW'(2 ** (SH - 1));
            assign r = (p_wide + HALF) >>> SH;
        end else begin : g_trunc
            assign r = p_wide >>> SH;
        end
    endgenerate

    assign rx = {{(XW-RW){r[RW-1]}}, r};

    always_comb begin
        sat_val  = rx[OW-1:0];
        sat_flag = 1'b0;
        if (rx > MAXV) begin
            sat_val  = {1'b0, {(OW-1){1'b1}}};
            sat_flag = 1'b1;
        end else if (rx < MINV) begin
            sat_val  = {1'b1, {(OW-1){1'b0}}};
            sat_flag = 1'b1;
        end
    end

    assign s2_adv   = s1_valid & (~out_valid | out_ready);
    assign in_ready = ~clear & (~s1_valid | s2_adv);
    assign accept   = in_valid & in_ready;
    assign consume  = out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_p      <= '0;
            out_valid <= 1'b0;
            out       <= '0;
            out_sat   <= 1'b0;
            sat_count <= '0;
        end else if (clear) begin
            // out/out_sat keep their old contents; out_valid=0 marks them stale.
            s1_valid  <= 1'b0;
            out_valid <= 1'b0;
            sat_count <= '0;
        end else begin
            // A new accept overrides the drain of S1, so back-to-back data has no bubble.
            if (accept) begin
                s1_p     <= prod;
                s1_valid <= 1'b1;
            end else if (s2_adv) begin
                s1_valid <= 1'b0;
            end

            if (s2_adv) begin
                out       <= sat_val;
                out_sat   <= sat_flag;
                out_valid <= 1'b1;
            end else if (consume) begin
                out_valid <= 1'b0;
            end

            if (consume && out_sat && (sat_count != {CW{1'b1}})) begin
                sat_count <= sat_count + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_sigmoid_alu_mult_pipe.sv
// tb/tb_sigmoid_alu_mult_pipe.sv - directed-vector bench for sigmoid_alu_mult_pipe
module tb_sigmoid_alu_mult_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       clear;
    logic       in_valid;
    logic       out_ready;
    logic [3:0] signval;
    logic [3:0] unsignval;

    // a: defaults; b: OW=6 OFRAC=2 ROUND=1; c: OW=6 OFRAC=2 ROUND=0
    logic       in_ready_a, in_ready_b, in_ready_c;
    logic       out_valid_a, out_valid_b, out_valid_c;
    logic [7:0] out_a;
    logic [5:0] out_b, out_c;
    logic       out_sat_a, out_sat_b, out_sat_c;
    logic [7:0] sat_count_a, sat_count_b, sat_count_c;

    int errors = 0;
    int checks = 0;
    int exp_cnt_b = 0;

    always #5 clk = ~clk;

    sigmoid_alu_mult_pipe u_a (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready_a),
        .signval(signval), .unsignval(unsignval),
        .out_valid(out_valid_a), .out_ready(out_ready),
        .out(out_a), .out_sat(out_sat_a), .sat_count(sat_count_a)
    );

    sigmoid_alu_mult_pipe #(.OW(6), .OFRAC(2), .ROUND(1)) u_b (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready_b),
        .signval(signval), .unsignval(unsignval),
        .out_valid(out_valid_b), .out_ready(out_ready),
        .out(out_b), .out_sat(out_sat_b), .sat_count(sat_count_b)
    );

    sigmoid_alu_mult_pipe #(.OW(6), .OFRAC(2), .ROUND(0)) u_c (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready_c),
        .signval(signval), .unsignval(unsignval),
        .out_valid(out_valid_c), .out_ready(out_ready),
        .out(out_c), .out_sat(out_sat_c), .sat_count(sat_count_c)
    );

    typedef struct {
        logic [3:0] s;
        logic [3:0] u;
        logic [7:0] ea;
        logic [7:0] eb;
        logic       sb;
        logic [7:0] ec;
        logic       sc;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    // Independent reference: full product, floor or round-half-up shift, clip.
    function automatic void ref_out(input logic [3:0] s, input logic [3:0] u, input int sh,
                                    input int rnd, input int ow,
                                    output logic [7:0] o, output logic sat);
        int p, r, mx, mn;
        p  = $signed(s) * int'(u);
        r  = p;
        if (sh > 0) begin
            if (rnd != 0) r = r + (1 << (sh - 1));
            r = r >>> sh;
        end
        mx  = (1 << (ow - 1)) - 1;
        mn  = -(1 << (ow - 1));
        sat = 1'b0;
        if (r > mx) begin r = mx; sat = 1'b1; end
        else if (r < mn) begin r = mn; sat = 1'b1; end
        o = 8'(r & ((1 << ow) - 1));
    endfunction

    task automatic send_one(input logic [3:0] s, input logic [3:0] u,
                            input logic [7:0] ea, input logic [7:0] eb, input logic sb,
                            input logic [7:0] ec, input logic sc);
        @(negedge clk);
        signval = s; unsignval = u; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("latency_not_yet", int'(out_valid_a), 0);
        @(negedge clk);
        chk("out_valid_a", int'(out_valid_a), 1);
        chk("out_a", int'(out_a), int'(ea));
        chk("out_sat_a", int'(out_sat_a), 0);
        chk("out_b", int'(out_b), int'(eb));
        chk("out_sat_b", int'(out_sat_b), int'(sb));
        chk("out_c", int'(out_c), int'(ec));
        chk("out_sat_c", int'(out_sat_c), int'(sc));
        if (sb && exp_cnt_b < 255) exp_cnt_b++;
        @(negedge clk);
        chk("sat_count_b", int'(sat_count_b), exp_cnt_b);
        chk("consumed", int'(out_valid_a), 0);
    endtask

    task automatic run_stream(input int n, input bit full);
        logic [7:0] q[$];
        logic [7:0] e, prev_out;
        logic       es;
        int sent = 0, got = 0, cyc = 0, first = -1, last = -1;
        bit prev_stall = 0;
        while (got < n && cyc < 400) begin
            @(negedge clk);
            out_ready = full ? 1'b1 : 1'($urandom_range(0, 1));
            in_valid  = (sent < n) && (full || $urandom_range(0, 3) != 0);
            signval   = 4'($urandom);
            unsignval = 4'($urandom);
            #1;
            if (prev_stall) begin
                chk("hold_valid", int'(out_valid_a), 1);
                chk("hold_out", int'(out_a), int'(prev_out));
            end
            if (full && sent < n) chk("full_in_ready", int'(in_ready_a), 1);
            if (out_valid_a && out_ready) begin
                if (q.size() == 0) begin
                    chk("stream_spurious", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("stream_out", int'(out_a), int'(e));
                end
                got++;
                if (first < 0) first = cyc;
                last = cyc;
            end
            prev_stall = out_valid_a && !out_ready;
            prev_out   = out_a;
            if (in_valid && in_ready_a) begin
                ref_out(signval, unsignval, 0, 0, 8, e, es);
                q.push_back(e);
                sent++;
                chk("in_flight_le2", int'(q.size() <= 2), 1);
            end
            cyc++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("stream_count", got, n);
        if (full) chk("consecutive", last - first, n - 1);
    endtask

    task automatic fill_both;
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; signval = 4'h7; unsignval = 4'hF;
        @(negedge clk);
        signval = 4'h3; unsignval = 4'h5;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("full_out_valid", int'(out_valid_a), 1);
        chk("full_in_ready_low", int'(in_ready_a), 0);
    endtask

    initial begin
        logic [7:0] ea, eb, ec;
        logic       sa, sb, sc;

        vecs[0] = '{4'h8, 4'hF, 8'h88, 8'h20, 1'b1, 8'h20, 1'b1};
        vecs[1] = '{4'h7, 4'hF, 8'h69, 8'h1F, 1'b1, 8'h1F, 1'b1};
        vecs[2] = '{4'h0, 4'h9, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[3] = '{4'hF, 4'h1, 8'hFF, 8'h00, 1'b0, 8'h3F, 1'b0};
        vecs[4] = '{4'h3, 4'h5, 8'h0F, 8'h08, 1'b0, 8'h07, 1'b0};
        vecs[5] = '{4'hD, 4'h8, 8'hE8, 8'h34, 1'b0, 8'h34, 1'b0};
        vecs[6] = '{4'h7, 4'h1, 8'h07, 8'h04, 1'b0, 8'h03, 1'b0};
        vecs[7] = '{4'h8, 4'h0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[8] = '{4'h5, 4'hD, 8'h41, 8'h1F, 1'b1, 8'h1F, 1'b1};
        vecs[9] = '{4'hB, 4'h7, 8'hDD, 8'h2F, 1'b0, 8'h2E, 1'b0};

        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        signval = '0; unsignval = '0;
        #12;
        chk("rst_out_valid", int'(out_valid_a), 0);
        chk("rst_out", int'(out_a), 0);
        chk("rst_out_sat", int'(out_sat_a), 0);
        chk("rst_sat_count", int'(sat_count_b), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", int'(in_ready_a), 1);

        foreach (vecs[i])
            send_one(vecs[i].s, vecs[i].u, vecs[i].ea, vecs[i].eb, vecs[i].sb, vecs[i].ec, vecs[i].sc);

        for (int s = 0; s < 16; s++) begin
            for (int u = 0; u < 16; u++) begin
                ref_out(4'(s), 4'(u), 0, 0, 8, ea, sa);
                ref_out(4'(s), 4'(u), 1, 1, 6, eb, sb);
                ref_out(4'(s), 4'(u), 1, 0, 6, ec, sc);
                send_one(4'(s), 4'(u), ea, eb, sb, ec, sc);
            end
        end

        run_stream(10, 1'b0);
        run_stream(20, 1'b1);

        fill_both();
        clear = 1'b1; in_valid = 1'b1; signval = 4'h1; unsignval = 4'h1;
        #1;
        chk("clear_in_ready", int'(in_ready_a), 0);
        @(negedge clk);
        clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        #1;
        chk("clear_out_valid", int'(out_valid_a), 0);
        chk("clear_sat_count", int'(sat_count_b), 0);
        chk("clear_in_ready_after", int'(in_ready_a), 1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("clear_no_stale", int'(out_valid_a), 0);
        end
        exp_cnt_b = 0;
        send_one(4'h7, 4'hF, 8'h69, 8'h1F, 1'b1, 8'h1F, 1'b1);

        fill_both();
        #1;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", int'(out_valid_a), 0);
        chk("arst_out", int'(out_a), 0);
        chk("arst_out_sat_b", int'(out_sat_b), 0);
        chk("arst_sat_count", int'(sat_count_b), 0);
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b1;
        #1;
        chk("arst_in_ready", int'(in_ready_a), 1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("arst_no_stale", int'(out_valid_a), 0);
        end
        exp_cnt_b = 0;
        send_one(4'h8, 4'hF, 8'h88, 8'h20, 1'b1, 8'h20, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
